butterfly_pipe: RTL

Pipelined, fully parametrised radix-2 FFT butterfly computing c = a + w·b, d = a − w·b on signed fixed-point complex operands. It replaces the iterative-multiplier butterfly in FFT stage datapaths with these changes:
- accepts one operand set per cycle at a fixed 3-cycle latency;
- selects the twiddle mode at runtime rather than at elaboration;
- adds optional ½ scaling and saturation with an overflow flag.

---
 rtl/butterfly_pkg.sv | 9 +
 rtl/butterfly_pipe_if.sv | 21 ++
 rtl/butterfly_pipe_cmult.sv | 64 ++++++
 rtl/butterfly_pipe.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Shared constants for the pipelined radix-2 butterfly: twiddle mode codes and latency.
package butterfly_pkg;
    localparam logic [2:0] MODE_MUL = 3'd0;
    localparam logic [2:0] MODE_P1  = 3'd1;
    localparam logic [2:0] MODE_M1  = 3'd2;
    localparam logic [2:0] MODE_PJ  = 3'd3;
    localparam logic [2:0] MODE_MJ  = 3'd4;
    localparam int         BFLY_LAT = 3;
endpackage

// File: rtl/butterfly_pipe_if.sv
// Operand/result handshake bundle for butterfly_pipe; slave is the butterfly side.
interface butterfly_pipe_if #(parameter int n = 32);
    logic                recv_val;
    logic                recv_rdy;
    logic signed [n-1:0] ar, ac, br, bc, wr, wc;
    logic [2:0]          mode;
    logic                scale;
    logic                send_val;
    logic                send_rdy;
    logic signed [n-1:0] cr, cc, dr, dc;
    logic                ovf;

    modport slave (
        input  recv_val, ar, ac, br, bc, wr, wc, mode, scale, send_rdy,
        output recv_rdy, send_val, cr, cc, dr, dc, ovf
    );
    modport master (
        output recv_val, ar, ac, br, bc, wr, wc, mode, scale, send_rdy,
        input  recv_rdy, send_val, cr, cc, dr, dc, ovf
    );
endinterface

// File: rtl/butterfly_pipe_cmult.sv
// Two-stage complex multiply t = b*w: stage 1 registers the d-shifted partial products,
// stage 2 registers the combined, saturated result and its overflow flag.
module cmult_pipe #(
    parameter int n = 32,
    parameter int d = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [n-1:0] br,
    input  logic signed [n-1:0] bc,
    input  logic signed [n-1:0] wr,
    input  logic signed [n-1:0] wc,
    output logic signed [n-1:0] tr,
    output logic signed [n-1:0] tc,
    output logic                ovf
);
    localparam int W = 2 * n;

    logic signed [W-1:0] m_rr, m_cc, m_rc, m_cr;
    logic signed [W-1:0] p_rr, p_cc, p_rc, p_cr;
    logic signed [W:0]   s_r, s_c;
    logic [W-n+1:0]      hi_r, hi_c;
    logic                fit_r, fit_c;

    assign m_rr = W'(br) * W'(wr);
    assign m_cc = W'(bc) * W'(wc);
    assign m_rc = W'(br) * W'(wc);
    assign m_cr = W'(bc) * W'(wr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_rr <= '0;
            p_cc <= '0;
            p_rc <= '0;
            p_cr <= '0;
        end else if (en) begin
            p_rr <= m_rr >>> d;
            p_cc <= m_cc >>> d;
            p_rc <= m_rc >>> d;
            p_cr <= m_cr >>> d;
        end
    end

    // Sums kept at full precision; a value fits n bits when its top bits are all equal.
    assign s_r   = (W+1)'(p_rr) - (W+1)'(p_cc);
    assign s_c   = (W+1)'(p_rc) + (W+1)'(p_cr);
    assign hi_r  = s_r[W:n-1];
    assign hi_c  = s_c[W:n-1];
    assign fit_r = (&hi_r) | ~(|hi_r);
    assign fit_c = (&hi_c) | ~(|hi_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tr  <= '0;
            tc  <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            tr  <= fit_r ? s_r[n-1:0] : (s_r[W] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}});
            tc  <= fit_c ? s_c[n-1:0] : (s_c[W] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}});
            ovf <= ~fit_r | ~fit_c;
        end
    end
endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 butterfly c = a + w*b, d = a - w*b, 3-cycle latency, runtime twiddle
// mode, optional 1/2 scaling and saturation with a per-item overflow flag.
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int n = 32,
    parameter int d = 16
) (
    input logic            clk,
    input logic            reset,
    butterfly_pipe_if.slave bus
);
    localparam logic signed [n-1:0] SMIN = {1'b1, {(n-1){1'b0}}};
    localparam logic signed [n-1:0] SMAX = {1'b0, {(n-1){1'b1}}};

    function automatic logic [n:0] neg_sat(input logic signed [n-1:0] x);
        return (x == SMIN) ? {1'b1, SMAX} : {1'b0, -x};
    endfunction

    // Returns {saturated, value}; the halved sum always fits, so scaling never saturates.
    function automatic logic [n:0] res_fix(input logic signed [n:0] s, input logic sc);
        if (sc)
            return {1'b0, s[n:1]};
        if (s[n] != s[n-1])
            return {1'b1, (s[n] ? SMIN : SMAX)};
        return {1'b0, s[n-1:0]};
    endfunction

    logic                en, accept;
    logic [BFLY_LAT:1]   vld_pipe;

    assign en           = ~bus.send_val | bus.send_rdy;
    assign bus.recv_rdy = en;
    assign accept       = bus.recv_val & en;
    assign bus.send_val = vld_pipe[BFLY_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[BFLY_LAT-1:1], accept};
    end

    // Bypass twiddles are pure sign/swap operations on b, resolved in S1.
    logic [n:0]          ng_r, ng_c;
    logic signed [n-1:0] bt_r, bt_c;
    logic                bt_o, bt_mul;

    assign ng_r = neg_sat(bus.br);
    assign ng_c = neg_sat(bus.bc);

    always_comb begin
        bt_r   = bus.br;
        bt_c   = bus.bc;
        bt_o   = 1'b0;
        bt_mul = 1'b0;
        case (bus.mode)
            MODE_P1: ;
            MODE_M1: begin
                bt_r = ng_r[n-1:0];
                bt_c = ng_c[n-1:0];
                bt_o = ng_r[n] | ng_c[n];
            end
            MODE_PJ: begin
                bt_r = ng_c[n-1:0];
                bt_c = bus.br;
                bt_o = ng_c[n];
            end
            MODE_MJ: begin
                bt_r = bus.bc;
                bt_c = ng_r[n-1:0];
                bt_o = ng_r[n];
            end
            default: bt_mul = 1'b1;
        endcase
    end

    logic signed [n-1:0] cm_tr, cm_tc;
    logic                cm_ovf;

    cmult_pipe #(.n(n), .d(d)) u_cmult (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .br    (bus.br),
        .bc    (bus.bc),
        .wr    (bus.wr),
        .wc    (bus.wc),
        .tr    (cm_tr),
        .tc    (cm_tc),
        .ovf   (cm_ovf)
    );

    // a, scale and the bypass result ride alongside the multiplier's two stages.
    logic signed [n-1:0] a1_r, a1_c, bt1_r, bt1_c, a2_r, a2_c, bt2_r, bt2_c;
    logic                bt1_o, mul1, sc1, bt2_o, mul2, sc2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_r  <= '0; a1_c  <= '0; bt1_r <= '0; bt1_c <= '0;
            bt1_o <= 1'b0; mul1 <= 1'b0; sc1 <= 1'b0;
            a2_r  <= '0; a2_c  <= '0; bt2_r <= '0; bt2_c <= '0;
            bt2_o <= 1'b0; mul2 <= 1'b0; sc2 <= 1'b0;
        end else if (en) begin
            a1_r  <= bus.ar; a1_c  <= bus.ac; bt1_r <= bt_r; bt1_c <= bt_c;
            bt1_o <= bt_o;   mul1  <= bt_mul; sc1   <= bus.scale;
            a2_r  <= a1_r;   a2_c  <= a1_c;   bt2_r <= bt1_r; bt2_c <= bt1_c;
            bt2_o <= bt1_o;  mul2  <= mul1;   sc2   <= sc1;
        end
    end

    logic signed [n-1:0] t_r, t_c;
    logic                t_o;
    logic signed [n:0]   s_cr, s_cc, s_dr, s_dc;
    logic [n:0]          f_cr, f_cc, f_dr, f_dc;

    assign t_r  = mul2 ? cm_tr  : bt2_r;
    assign t_c  = mul2 ? cm_tc  : bt2_c;
    assign t_o  = mul2 ? cm_ovf : bt2_o;
    assign s_cr = {a2_r[n-1], a2_r} + {t_r[n-1], t_r};
    assign s_cc = {a2_c[n-1], a2_c} + {t_c[n-1], t_c};
    assign s_dr = {a2_r[n-1], a2_r} - {t_r[n-1], t_r};
    assign s_dc = {a2_c[n-1], a2_c} - {t_c[n-1], t_c};
    assign f_cr = res_fix(s_cr, sc2);
    assign f_cc = res_fix(s_cc, sc2);
    assign f_dr = res_fix(s_dr, sc2);
    assign f_dc = res_fix(s_dc, sc2);

    // Outputs only move when a valid item enters S3, so bubbles leave them untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cr  <= '0;
            bus.cc  <= '0;
            bus.dr  <= '0;
            bus.dc  <= '0;
            bus.ovf <= 1'b0;
        end else if (en && vld_pipe[BFLY_LAT-1]) begin
            bus.cr  <= f_cr[n-1:0];
            bus.cc  <= f_cc[n-1:0];
            bus.dr  <= f_dr[n-1:0];
            bus.dc  <= f_dc[n-1:0];
            bus.ovf <= t_o | f_cr[n] | f_cc[n] | f_dr[n] | f_dc[n];
        end
    end
endmodule
